block_window_loader: RTL and testbench
======================================

Name: block_window_loader

Overview:
- Upstream feeder for the 3D block selector. It supplies the 12-slot block set (x/y/z/color/direction/ID/visible) that the selector muxes per pixel.
- Once per frame it scans the block memory sequentially and keeps the first NUM_SLOTS visible blocks whose z lies inside a depth window ahead of the camera, where camera z is derived from curr_time.
- Results build in shadow registers and are committed atomically, so the outputs hold stable for the whole frame.

Parameters:
- NUM_SLOTS, 12, number of output slots (fixed to 12 by the selector interface).
- NUM_BLOCKS, 256, entries in block memory (2..256).
- ADDR_W, 8, block memory address width.
- WINDOW_Z, 4096, depth window width in z units.
- TIME_SHIFT, 4, camera z = curr_time_in[TIME_SHIFT+13:TIME_SHIFT] (max 4).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low.
- frame_start_in  in  1  one-cycle pulse starting a scan.
- curr_time_in  in  18  song time, latched at scan start.
- mem_addr_out  out  ADDR_W  block memory address.
- mem_rd_out  out  1  read strobe; data returns the following cycle.
- mem_x_in / mem_y_in  in  12 each  block x/y.
- mem_z_in  in  14  block z.
- mem_color_in  in  1  block color.
- mem_direction_in  in  3  cut direction.
- mem_visible_in  in  1  block not yet destroyed.
- block_x_out / block_y_out  out  [11:0][11:0]  slot x/y.
- block_z_out  out  [11:0][13:0]  slot z.
- block_color_out  out  12  per-slot color.
- block_direction_out  out  [11:0][2:0].
- block_ID_out  out  [11:0][7:0]  memory address of the slot's block.
- block_visible_out  out  12  slot valid.
- busy_out  out  1  scan in progress.
- load_done_out  out  1  one-cycle pulse on commit.
- dropped_frame_out  out  1  one-cycle pulse when frame_start_in arrives while busy.

Behaviour:
- Reset (rst_in low at a clock edge):
  - state IDLE.
  - All outputs 0, including every slot field, block_visible_out, busy, pulses, mem_rd_out and mem_addr_out.
  - Shadow registers cleared.
  - A reset mid-scan aborts the scan with no commit.
- FSM IDLE -> SCAN -> DRAIN -> COMMIT -> IDLE.
- IDLE:
  - frame_start_in latches cam_z and clears the shadow slots and fill count.
  - Next state SCAN, busy_out=1.
- SCAN:
  - Cycle numbering: cycle 0 is the cycle in which frame_start_in is high.
  - Address k is presented with mem_rd_out=1 in cycle k+1, for k=0..NUM_BLOCKS-1.
  - Data k is sampled at the end of cycle k+2.
- Accept rule:
  - diff = {1'b0,z} - {1'b0,cam_z}, 15 bits.
  - Accept iff mem_visible_in=1 AND diff[14]=0 AND diff[13:0] < WINDOW_Z.
  - cam_z is accepted (inclusive); cam_z+WINDOW_Z is rejected.
  - No wrap: z < cam_z is always rejected.
- Slot fill:
  - An accepted block goes to slot[fill], with ID = its address zero-extended to 8 bits; then fill++.
  - Slots fill in address order.
- Early stop:
  - When fill reaches NUM_SLOTS, mem_rd_out drops the next cycle.
  - Data from any read already in flight is discarded.
  - Next state COMMIT.
- DRAIN: after the last address is issued, wait one cycle for the final data, then COMMIT.
- COMMIT (one cycle):
  - Shadow copied to outputs.
  - block_visible_out[i] = (i < fill).
  - Unfilled slots have all fields 0.
  - In the following cycle load_done_out=1 and busy_out=0.
- Timing:
  - Full scan: new outputs and load_done_out appear in cycle NUM_BLOCKS+3.
  - Early stop with the 12th accept at address k: they appear in cycle k+4.
- Outputs change only on commit and are held through the scan.
- frame_start_in while busy:
  - Ignored; the scan continues unchanged.
  - dropped_frame_out pulses the next cycle.
- frame_start_in in the same cycle as load_done_out is accepted (the FSM is IDLE).
- Zero accepts: commit with block_visible_out=0.

Test Plan:
- Reset: hold rst_in=0 for 2 cycles with frame_start_in=1 -> all outputs 0, busy_out=0, mem_rd_out=0.
- NUM_BLOCKS=16, curr_time=0, addresses 2,5,6,9,13 in-window and visible -> load_done_out in cycle 19; slots 0..4 have IDs 2,5,6,9,13 and fields match memory; block_visible_out=12'h01F; slots 5..11 all zero.
- NUM_BLOCKS=32, all 32 in-window -> IDs 0..11, block_visible_out=12'hFFF; mem_rd_out low from cycle 15 (addresses up to 13 issued); load_done_out in cycle 15.
- Boundary: curr_time=1600 (cam_z=100), z=99/100/4195/4196 plus z=150 with mem_visible_in=0 -> only z=100 and z=4195 accepted, block_visible_out=12'h003.
- frame_start_in in cycle 5 of a 16-block scan -> dropped_frame_out high in cycle 6; load_done_out still in cycle 19; outputs stay at the previous frame's values until then.
- rst_in=0 in cycle 8 of a scan -> outputs zero, no load_done_out; a fresh frame_start_in afterwards completes normally with correct slots.

Source files
------------

// File: rtl/block_window_loader.sv
// Per-frame scanner for the block selector: reads block memory in address order and keeps the
// first NUM_SLOTS visible blocks inside the depth window ahead of the camera, committed atomically.
module block_window_loader #(
  parameter int NUM_SLOTS  = 12,
  parameter int NUM_BLOCKS = 256,
  parameter int ADDR_W     = 8,
  parameter int WINDOW_Z   = 4096,
  parameter int TIME_SHIFT = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           frame_start_in,
  input  logic [17:0]                    curr_time_in,
  output logic [ADDR_W-1:0]              mem_addr_out,
  output logic                           mem_rd_out,
  input  logic [11:0]                    mem_x_in,
  input  logic [11:0]                    mem_y_in,
  input  logic [13:0]                    mem_z_in,
  input  logic                           mem_color_in,
  input  logic [2:0]                     mem_direction_in,
  input  logic                           mem_visible_in,
  output logic [NUM_SLOTS-1:0][11:0]     block_x_out,
  output logic [NUM_SLOTS-1:0][11:0]     block_y_out,
  output logic [NUM_SLOTS-1:0][13:0]     block_z_out,
  output logic [NUM_SLOTS-1:0]           block_color_out,
  output logic [NUM_SLOTS-1:0][2:0]      block_direction_out,
  output logic [NUM_SLOTS-1:0][7:0]      block_ID_out,
  output logic [NUM_SLOTS-1:0]           block_visible_out,
  output logic                           busy_out,
  output logic                           load_done_out,
  output logic                           dropped_frame_out
);

  localparam int FILL_W = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

  state_t                       state_q, state_n;
  logic                         rd_n;
  logic [ADDR_W-1:0]            addr_n;
  logic                         rd_valid_q;
  logic [ADDR_W-1:0]            rd_addr_q;
  logic [13:0]                  cam_z_q;
  logic [FILL_W-1:0]            fill_q;
  logic [14:0]                  z_diff;
  logic                         in_window;
  logic                         take;
  logic                         last_take;
  logic                         last_addr;
  logic                         unused_time;

  logic [NUM_SLOTS-1:0][11:0]   sh_x;
  logic [NUM_SLOTS-1:0][11:0]   sh_y;
  logic [NUM_SLOTS-1:0][13:0]   sh_z;
  logic [NUM_SLOTS-1:0]         sh_color;
  logic [NUM_SLOTS-1:0][2:0]    sh_dir;
  logic [NUM_SLOTS-1:0][7:0]    sh_id;
  logic [NUM_SLOTS-1:0]         sh_vis;

  // Only a 14-bit slice of the song time is used as camera z.
  assign unused_time = ^curr_time_in;

  // Read-data qualification: z below the camera makes the 15-bit difference negative.
  always_comb begin
    z_diff    = {1'b0, mem_z_in} - {1'b0, cam_z_q};
    in_window = mem_visible_in && !z_diff[14] && ({1'b0, z_diff[13:0]} < 15'(WINDOW_Z));
    take      = (state_q == SCAN || state_q == DRAIN) && rd_valid_q && in_window;
    last_take = take && (fill_q == FILL_W'(NUM_SLOTS - 1));
    last_addr = (mem_addr_out == ADDR_W'(NUM_BLOCKS - 1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_n;
  end

  // The read issued alongside the final accept still goes out; its data is never used.
  always_comb begin
    state_n = state_q;
    rd_n    = 1'b0;
    addr_n  = mem_addr_out;
    unique case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          state_n = SCAN;
          rd_n    = 1'b1;
          addr_n  = '0;
        end
      end
      SCAN: begin
        rd_n = !last_addr;
        if (!last_addr) addr_n = mem_addr_out + 1'b1;
        if (last_take)      state_n = COMMIT;
        else if (last_addr) state_n = DRAIN;
      end
      DRAIN:   state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_rd_out          <= 1'b0;
      mem_addr_out        <= '0;
      rd_valid_q          <= 1'b0;
      rd_addr_q           <= '0;
      busy_out            <= 1'b0;
      load_done_out       <= 1'b0;
      dropped_frame_out   <= 1'b0;
      cam_z_q             <= '0;
      fill_q              <= '0;
      sh_x                <= '0;
      sh_y                <= '0;
      sh_z                <= '0;
      sh_color            <= '0;
      sh_dir              <= '0;
      sh_id               <= '0;
      sh_vis              <= '0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= '0;
      block_direction_out <= '0;
      block_ID_out        <= '0;
      block_visible_out   <= '0;
    end else begin
      mem_rd_out        <= rd_n;
      mem_addr_out      <= addr_n;
      rd_valid_q        <= mem_rd_out;
      rd_addr_q         <= mem_addr_out;
      busy_out          <= (state_n != IDLE);
      load_done_out     <= (state_q == COMMIT);
      dropped_frame_out <= frame_start_in && (state_q != IDLE);

      if (state_q == IDLE && frame_start_in) begin
        cam_z_q  <= curr_time_in[TIME_SHIFT+13 -: 14];
        fill_q   <= '0;
        sh_x     <= '0;
        sh_y     <= '0;
        sh_z     <= '0;
        sh_color <= '0;
        sh_dir   <= '0;
        sh_id    <= '0;
        sh_vis   <= '0;
      end else if (take) begin
        sh_x[fill_q]     <= mem_x_in;
        sh_y[fill_q]     <= mem_y_in;
        sh_z[fill_q]     <= mem_z_in;
        sh_color[fill_q] <= mem_color_in;
        sh_dir[fill_q]   <= mem_direction_in;
        sh_id[fill_q]    <= 8'(rd_addr_q);
        sh_vis[fill_q]   <= 1'b1;
        fill_q           <= fill_q + 1'b1;
      end

      // Slots beyond the fill count were cleared at frame start, so a plain copy suffices.
      if (state_q == COMMIT) begin
        block_x_out         <= sh_x;
        block_y_out         <= sh_y;
        block_z_out         <= sh_z;
        block_color_out     <= sh_color;
        block_direction_out <= sh_dir;
        block_ID_out        <= sh_id;
        block_visible_out   <= sh_vis;
      end
    end
  end

endmodule

// File: tb/tb_block_window_loader.sv
// Randomized bench for block_window_loader: a behavioural memory feeds the scanner and a
// list-based window model predicts slot contents, commit cycle and the read sequence.
module tb_block_window_loader;

  localparam int NB = 16;
  localparam int NS = 12;
  localparam int WZ = 4096;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              frame_start_in = 1'b0;
  logic [17:0]       curr_time_in = '0;
  logic [7:0]        mem_addr_out;
  logic              mem_rd_out;
  logic [11:0]       mem_x_in, mem_y_in;
  logic [13:0]       mem_z_in;
  logic              mem_color_in;
  logic [2:0]        mem_direction_in;
  logic              mem_visible_in;
  logic [11:0][11:0] block_x_out, block_y_out;
  logic [11:0][13:0] block_z_out;
  logic [11:0]       block_color_out;
  logic [11:0][2:0]  block_direction_out;
  logic [11:0][7:0]  block_ID_out;
  logic [11:0]       block_visible_out;
  logic              busy_out, load_done_out, dropped_frame_out;

  block_window_loader #(
    .NUM_SLOTS(NS), .NUM_BLOCKS(NB), .ADDR_W(8), .WINDOW_Z(WZ), .TIME_SHIFT(4)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .curr_time_in(curr_time_in), .mem_addr_out(mem_addr_out), .mem_rd_out(mem_rd_out),
    .mem_x_in(mem_x_in), .mem_y_in(mem_y_in), .mem_z_in(mem_z_in),
    .mem_color_in(mem_color_in), .mem_direction_in(mem_direction_in),
    .mem_visible_in(mem_visible_in), .block_x_out(block_x_out), .block_y_out(block_y_out),
    .block_z_out(block_z_out), .block_color_out(block_color_out),
    .block_direction_out(block_direction_out), .block_ID_out(block_ID_out),
    .block_visible_out(block_visible_out), .busy_out(busy_out),
    .load_done_out(load_done_out), .dropped_frame_out(dropped_frame_out)
  );

  // ---------------- clock / counters ----------------
  always #5 clk_in = ~clk_in;

  int cyc_cnt = 0;
  int start_cyc = 0;
  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- block memory ----------------
  logic [11:0] mem_x[NB];
  logic [11:0] mem_y[NB];
  logic [13:0] mem_z[NB];
  logic        mem_color[NB];
  logic [2:0]  mem_dir[NB];
  logic        mem_vis[NB];

  // Junk on the bus whenever no read is pending.
  always @(posedge clk_in) begin
    if (mem_rd_out) begin
      mem_x_in         <= mem_x[mem_addr_out[3:0]];
      mem_y_in         <= mem_y[mem_addr_out[3:0]];
      mem_z_in         <= mem_z[mem_addr_out[3:0]];
      mem_color_in     <= mem_color[mem_addr_out[3:0]];
      mem_direction_in <= mem_dir[mem_addr_out[3:0]];
      mem_visible_in   <= mem_vis[mem_addr_out[3:0]];
    end else begin
      mem_x_in         <= 12'($urandom);
      mem_y_in         <= 12'($urandom);
      mem_z_in         <= 14'($urandom);
      mem_color_in     <= 1'($urandom);
      mem_direction_in <= 3'($urandom);
      mem_visible_in   <= 1'($urandom);
    end
  end

  int rd_cyc_q[$];
  int rd_a_q[$];
  always @(negedge clk_in) begin
    if (mem_rd_out) begin
      rd_cyc_q.push_back(cyc_cnt - start_cyc);
      rd_a_q.push_back(int'(mem_addr_out));
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [49:0] exp_q[$];
  logic [49:0] prev_slot[NS];
  logic [11:0] prev_vis;
  int exp_cycle;
  int exp_reads;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [49:0] dut_slot(input int i);
    return {block_x_out[i], block_y_out[i], block_z_out[i], block_color_out[i],
            block_direction_out[i], block_ID_out[i]};
  endfunction

  function automatic logic [11:0] vis_mask(input int n);
    logic [12:0] m;
    m = (13'd1 << n) - 13'd1;
    return m[11:0];
  endfunction

  function automatic int hold_diff();
    int d = 0;
    for (int i = 0; i < NS; i++) if (dut_slot(i) !== prev_slot[i]) d++;
    if (block_visible_out !== prev_vis) d++;
    return d;
  endfunction

  function automatic int nonzero_slots();
    int d = 0;
    for (int i = 0; i < NS; i++) if (dut_slot(i) !== 50'd0) d++;
    return d;
  endfunction

  // Reference: walk the memory in address order, keep the first NS blocks in [cam, cam+WZ).
  task automatic model_frame(input logic [17:0] t);
    int cam, z, k12;
    exp_q.delete();
    cam = int'(t >> 4) % 16384;
    k12 = -1;
    for (int a = 0; a < NB; a++) begin
      z = int'(mem_z[a]);
      if (exp_q.size() < NS && mem_vis[a] && z >= cam && z - cam < WZ) begin
        exp_q.push_back({mem_x[a], mem_y[a], mem_z[a], mem_color[a], mem_dir[a], 8'(a)});
        if (exp_q.size() == NS) k12 = a;
      end
    end
    if (k12 >= 0) begin
      exp_cycle = k12 + 4;
      exp_reads = (k12 + 3 < NB) ? k12 + 3 : NB;
    end else begin
      exp_cycle = NB + 3;
      exp_reads = NB;
    end
  endtask

  task automatic check_slots(input string tag);
    logic [49:0] e;
    for (int i = 0; i < NS; i++) begin
      e = (i < exp_q.size()) ? exp_q[i] : 50'd0;
      check($sformatf("%s_slot%0d", tag, i), dut_slot(i), e);
      prev_slot[i] = e;
    end
    check({tag, "_visible"}, block_visible_out, vis_mask(exp_q.size()));
    prev_vis = vis_mask(exp_q.size());
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_slots"}, nonzero_slots(), 0);
    check({tag, "_visible"}, block_visible_out, 12'h000);
    check({tag, "_ctrl"}, {busy_out, load_done_out, dropped_frame_out, mem_rd_out, mem_addr_out}, 12'h000);
  endtask

  // ---------------- drivers ----------------
  task automatic randomize_fields();
    for (int a = 0; a < NB; a++) begin
      mem_x[a]     = 12'($urandom);
      mem_y[a]     = 12'($urandom);
      mem_color[a] = 1'($urandom);
      mem_dir[a]   = 3'($urandom);
    end
  endtask

  // cam_z = 0; exactly addresses 2,5,6,9,13 are visible and in-window.
  task automatic load_sparse();
    randomize_fields();
    for (int a = 0; a < NB; a++) begin
      if (a == 2 || a == 5 || a == 6 || a == 9 || a == 13) begin
        mem_vis[a] = 1'b1;
        mem_z[a]   = 14'($urandom_range(0, WZ - 1));
      end else if (a % 2 == 1) begin
        mem_vis[a] = 1'b0;
        mem_z[a]   = 14'($urandom_range(0, WZ - 1));
      end else begin
        mem_vis[a] = 1'b1;
        mem_z[a]   = 14'($urandom_range(WZ, 16383));
      end
    end
  endtask

  task automatic load_random(input int cam);
    int z;
    randomize_fields();
    for (int a = 0; a < NB; a++) begin
      z = cam + int'($urandom_range(0, 7000)) - 1500;
      if (z < 0) z = 0;
      if (z > 16383) z = 16383;
      mem_z[a]   = 14'(z);
      mem_vis[a] = ($urandom_range(0, 4) != 0);
    end
  endtask

  // now=1 starts the frame in the current cycle (used right after a load_done sample).
  task automatic run_frame(input string tag, input logic [17:0] t, input int drop_at, input bit now);
    int got_cyc, drop_seen, hold_bad, busy_bad, seq_bad, exp_drop;
    logic busy_at_done;
    model_frame(t);
    if (!now) begin
      @(posedge clk_in); #1;
    end
    rd_cyc_q.delete();
    rd_a_q.delete();
    curr_time_in   = t;
    frame_start_in = 1'b1;
    start_cyc      = cyc_cnt;
    @(posedge clk_in); #1;
    frame_start_in = 1'b0;
    curr_time_in   = 18'($urandom);
    got_cyc = -1; drop_seen = -1; hold_bad = 0; busy_bad = 0; seq_bad = 0;
    busy_at_done = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (c == drop_at) frame_start_in = 1'b1;
      @(negedge clk_in);
      if (dropped_frame_out && drop_seen < 0) drop_seen = c;
      if (load_done_out) begin
        got_cyc      = c;
        busy_at_done = busy_out;
        break;
      end
      if (hold_diff() != 0) hold_bad++;
      if (!busy_out) busy_bad++;
      @(posedge clk_in); #1;
      frame_start_in = 1'b0;
    end
    exp_drop = (drop_at > 0) ? drop_at + 1 : -1;
    for (int j = 0; j < rd_cyc_q.size(); j++)
      if (rd_cyc_q[j] != j + 1 || rd_a_q[j] != j) seq_bad++;
    check({tag, "_done_cycle"}, got_cyc, exp_cycle);
    check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
    check({tag, "_busy_during"}, busy_bad, 0);
    check({tag, "_outputs_held"}, hold_bad, 0);
    check({tag, "_dropped_cycle"}, drop_seen, exp_drop);
    check({tag, "_read_count"}, rd_cyc_q.size(), exp_reads);
    check({tag, "_read_sequence"}, seq_bad, 0);
    check_slots(tag);
  endtask

  task automatic reset_mid_scan();
    int done_seen;
    load_sparse();
    @(posedge clk_in); #1;
    curr_time_in   = 18'd0;
    frame_start_in = 1'b1;
    start_cyc      = cyc_cnt;
    @(posedge clk_in); #1;
    frame_start_in = 1'b0;
    repeat (7) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    check_zero_state("mid_rst");
    done_seen = 0;
    repeat (25) begin
      @(negedge clk_in);
      if (load_done_out) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    for (int i = 0; i < NS; i++) prev_slot[i] = '0;
    prev_vis = '0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [17:0] t;
    for (int i = 0; i < NS; i++) prev_slot[i] = '0;
    prev_vis = '0;
    for (int a = 0; a < NB; a++) begin
      mem_x[a] = '0; mem_y[a] = '0; mem_z[a] = '0;
      mem_color[a] = 1'b0; mem_dir[a] = '0; mem_vis[a] = 1'b0;
    end

    rst_in = 1'b0;
    frame_start_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check_zero_state("reset");
    frame_start_in = 1'b0;
    rst_in = 1'b1;

    load_sparse();
    run_frame("sparse", 18'd0, 0, 1'b0);

    randomize_fields();
    for (int a = 0; a < NB; a++) begin
      mem_vis[a] = 1'b1;
      mem_z[a]   = 14'($urandom_range(0, WZ - 1));
    end
    run_frame("early_stop", 18'd9, 0, 1'b0);

    randomize_fields();
    for (int a = 0; a < NB; a++) begin
      mem_vis[a] = 1'b1;
      mem_z[a]   = (a % 2 == 0) ? 14'd5000 : 14'd50;
    end
    mem_z[0] = 14'd99;   mem_z[1] = 14'd100;  mem_z[2] = 14'd4195;
    mem_z[3] = 14'd4196; mem_z[4] = 14'd150;  mem_vis[4] = 1'b0;
    run_frame("boundary", 18'd1600, 0, 1'b0);

    load_sparse();
    run_frame("drop", 18'd0, 5, 1'b0);

    reset_mid_scan();
    load_sparse();
    run_frame("after_rst", 18'd0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      t = 18'($urandom);
      load_random(int'(t >> 4));
      run_frame($sformatf("rand%0d", r), t, 0, r[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
